crc_checker: RTL
================

// Module: crc_checker
// PURPOSE
//  Receive-side check for the bit-serial CRC-16 frame produced by the sender's crc block.
//  Takes a 50-bit payload plus its 16-bit CRC and re-runs the same LFSR over all 66 bits, MSB-stream order.
//  Reports pass/fail, the final remainder (syndrome) and a saturating error count.
//  Sits in the receiver path between frame deserialiser and payload consumer.
// PARAMETERS
//  DATA_W    50        payload bits, index 0 shifted first
//  CRC_W     16        CRC width
//  POLY      16'h8005  generator x^16+x^15+x^2+1, taps at bits 15 and 2, plus feedback into bit 0
//  INIT      16'h0000  LFSR value loaded on start
//  ERRCNT_W  8         width of err_count
// PORTS
//  clk         in   1         rising-edge clock
//  rst_n       in   1         synchronous reset, active low
//  start       in   1         1-cycle request; rx_data/rx_crc sampled when accepted
//  rx_data     in   [0:49]    payload, bit 0 enters LFSR first
//  rx_crc      in   [15:0]    received CRC, bit 15 enters first (after rx_data[49])
//  busy        out  1         high from acceptance until the done cycle inclusive
//  done        out  1         1-cycle pulse, result valid
//  crc_ok      out  1         syndrome==0, held until next done
//  syndrome    out  [15:0]    final LFSR remainder, held until next done
//  data_out    out  [0:49]    captured payload, held until next done
//  err_count   out  [7:0]     count of failed frames, saturates at 255
// BEHAVIOUR
//  Reset: when rst_n==0 at a clk edge, all of the following take their reset values:
//   - FSM=IDLE.
//   - busy=0, done=0, crc_ok=0.
//   - syndrome=0, data_out=0, err_count=0.
//   - LFSR=INIT, bit counter=0.
//  Reset mid-frame aborts the frame with no done pulse.
//  FSM:
//   - IDLE: start=1 -> capture {rx_data,rx_crc} into a 66-bit shift register, LFSR=INIT, cnt=0, go to SHIFT.
//   - SHIFT: each cycle take the next bit b (rx_data[0..49], then rx_crc[15..0]).
//     s=lfsr[15]^b; lfsr<={lfsr[14]^s, lfsr[13:3], lfsr[2], lfsr[1]^s, lfsr[0], s}; cnt++.
//     After the shift with cnt==65, go to DONE.
//   - DONE: done=1; syndrome=lfsr; crc_ok=(lfsr==0); data_out=captured payload.
//     If lfsr!=0 and err_count!=255, err_count++. Next state IDLE.
//  Latency: start accepted at edge T; 66 SHIFT cycles; done high in cycle T+67; next start accepted at T+68 or later.
//  start while busy (SHIFT/DONE) is ignored, with no queuing.
//  rx_* may change freely after the acceptance edge.
//  cnt is 7 bits; it never wraps, because the FSM leaves SHIFT at 65.
//  Outputs other than done/busy change only in DONE.
// STRUCTURE
//  crc_pkg:
//   - CRC_W, DATA_W, FRAME_W=DATA_W+CRC_W, POLY, INIT.
//   - typedef of the state enum {IDLE,SHIFT,DONE}.
//   - function crc16_step(lfsr,bit) shared with the sender.
//  One sub-module: crc16_lfsr (clk, rst_n, clr, en, din, state[15:0]).
//  The same sub-module is reusable by the sender.
//  Top holds the FSM, frame shift register, counter and result registers.
// TESTING
//  1. Reset, then zero frame: rx_data=0, rx_crc=16'h0000, start
//     -> done at +67 cycles, crc_ok=1, syndrome=0, err_count=0.
//  2. rx_data=0, rx_crc=16'h0001
//     -> crc_ok=0, syndrome=16'h8005, err_count=1.
//  3. rx_data[49]=1 (others 0), rx_crc=16'h8005
//     -> crc_ok=1. Flip rx_data[0] in the same frame -> crc_ok=0, err_count increments.
//  4. Back-to-back: pulse start every cycle for 200 cycles
//     -> one frame accepted per 68 cycles, exactly one done each.
//  5. Assert rst_n=0 at SHIFT cycle 30
//     -> no done; all outputs at reset values; next frame checks correctly.
//  6. 260 corrupted frames
//     -> err_count stops at 255, crc_ok=0 on each done.

Source files
------------

// File: rtl/crc_checker_pkg.sv
// Shared constants, state type and the CRC-16 (0x8005) single-bit step used by
// both the receive-side checker and the sender.
package crc_checker_pkg;

   localparam int DATA_W   = 50;
   localparam int CRC_W    = 16;
   localparam int FRAME_W  = DATA_W + CRC_W;
   localparam int ERRCNT_W = 8;
   localparam int CNT_W    = 7;

   localparam logic [CRC_W-1:0]    POLY     = 16'h8005;
   localparam logic [CRC_W-1:0]    INIT     = 16'h0000;
   localparam logic [CNT_W-1:0]    LAST_CNT = 7'd65;
   localparam logic [ERRCNT_W-1:0] ERR_MAX  = 8'hFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // MSB-first step: shift left, fold POLY back in when the outgoing bit differs from din.
   function automatic logic [CRC_W-1:0] crc16_step(input logic [CRC_W-1:0] lfsr,
                                                   input logic             din);
      logic s;
      s = lfsr[CRC_W-1] ^ din;
      return {lfsr[CRC_W-2:0], 1'b0} ^ (s ? POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/crc_checker_if.sv
// Frame request / result bundle between the deserialiser, the CRC checker and
// the payload consumer.
interface crc_checker_if;
   import crc_checker_pkg::*;

   logic                start;
   logic [0:DATA_W-1]   rx_data;
   logic [CRC_W-1:0]    rx_crc;
   logic                busy;
   logic                done;
   logic                crc_ok;
   logic [CRC_W-1:0]    syndrome;
   logic [0:DATA_W-1]   data_out;
   logic [ERRCNT_W-1:0] err_count;

   modport master (
      output start, rx_data, rx_crc,
      input  busy, done, crc_ok, syndrome, data_out, err_count
   );

   modport slave (
      input  start, rx_data, rx_crc,
      output busy, done, crc_ok, syndrome, data_out, err_count
   );

endinterface

// File: rtl/crc_checker_lfsr.sv
// Bit-serial CRC-16 LFSR with synchronous clear; reusable on the sending side.
module crc16_lfsr
   import crc_checker_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic             din,
   output logic [CRC_W-1:0] state
);

   // LFSR register: clear has priority over the shift enable.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= INIT;
      end else if (clr) begin
         state <= INIT;
      end else if (en) begin
         state <= crc16_step(state, din);
      end else begin
         state <= state;
      end
   end

endmodule

// File: rtl/crc_checker.sv
// Receive-side CRC-16 check: runs payload then received CRC through the LFSR and
// reports pass/fail, syndrome and a saturating failed-frame count.
module crc_checker
   import crc_checker_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   crc_checker_if.slave bus
);

   state_t              state_r;
   logic [FRAME_W-1:0]  frame_r;
   logic [CNT_W-1:0]    cnt_r;
   logic                busy_r;
   logic                done_r;
   logic                crc_ok_r;
   logic [CRC_W-1:0]    syndrome_r;
   logic [0:DATA_W-1]   data_out_r;
   logic [ERRCNT_W-1:0] err_count_r;

   logic                lfsr_clr_s;
   logic                lfsr_en_s;
   logic [CRC_W-1:0]    lfsr_s;

   // LFSR control derived from the current FSM state.
   always_comb begin
      lfsr_clr_s = 1'b0;
      lfsr_en_s  = 1'b0;
      case (state_r)
         IDLE:    lfsr_clr_s = bus.start;
         SHIFT:   lfsr_en_s  = 1'b1;
         default: lfsr_en_s  = 1'b0;
      endcase
   end

   crc16_lfsr u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (lfsr_clr_s),
      .en    (lfsr_en_s),
      .din   (frame_r[FRAME_W-1]),
      .state (lfsr_s)
   );

   // FSM, frame register, bit counter and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         frame_r     <= {FRAME_W{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         crc_ok_r    <= 1'b0;
         syndrome_r  <= {CRC_W{1'b0}};
         data_out_r  <= {DATA_W{1'b0}};
         err_count_r <= {ERRCNT_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  frame_r <= {bus.rx_data, bus.rx_crc};
                  cnt_r   <= {CNT_W{1'b0}};
                  busy_r  <= 1'b1;
                  state_r <= SHIFT;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            SHIFT: begin
               // Rotate rather than shift so the payload is intact again after 66 steps.
               frame_r <= {frame_r[FRAME_W-2:0], frame_r[FRAME_W-1]};
               cnt_r   <= cnt_r + 7'd1;
               if (cnt_r == LAST_CNT) begin
                  state_r <= DONE;
               end else begin
                  state_r <= SHIFT;
               end
            end
            DONE: begin
               done_r     <= 1'b1;
               syndrome_r <= lfsr_s;
               crc_ok_r   <= (lfsr_s == 16'h0000);
               data_out_r <= frame_r[FRAME_W-1:CRC_W];
               if ((lfsr_s != 16'h0000) && (err_count_r != ERR_MAX)) begin
                  err_count_r <= err_count_r + 8'd1;
               end else begin
                  err_count_r <= err_count_r;
               end
               state_r <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.crc_ok    = crc_ok_r;
   assign bus.syndrome  = syndrome_r;
   assign bus.data_out  = data_out_r;
   assign bus.err_count = err_count_r;

endmodule
